// File: rtl/counter_monitor_pkg.sv
// Shared types and helpers for the counter monitor.
package counter_monitor_pkg;

  // Monitor states; the encodings are fixed so bench-side monitors can decode them.
  typedef enum logic [1:0] {
    StSync  = 2'd0,
    StTrack = 2'd1,
    StFault = 2'd2
  } state_e;

  // Width needed to hold a run length of 0..lock_cycles.
  function automatic int unsigned run_width(input int unsigned lock_cycles);
    return (lock_cycles < 1) ? 1 : $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/sat_incr.sv
// Registered saturating incrementer with synchronous active-low reset.
// i_zero takes priority over i_inc; the value sticks at all-ones.
module sat_incr #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_zero,
  output logic [Width-1:0] o_value
);

  logic [Width-1:0] r_value;

  // Tally register: reset/zero clear it, inc advances it until saturation.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_zero) begin
      r_value <= '0;
    end else if (i_inc && !(&r_value)) begin
      r_value <= r_value + Width'(1);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/counter_monitor.sv
// Watches a free-running counter bus, locks onto its +1 sequence, pulses on
// legal wraps and illegal steps, and keeps saturating tallies plus a capture
// of the first failure. All outputs are registered.
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int unsigned Size       = 5,
  parameter int unsigned LockCycles = 4,
  parameter int unsigned MaxErrors  = 3,
  parameter int unsigned WrapWidth  = 16,
  parameter int unsigned ErrWidth   = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,      // active-low, synchronous
  input  logic                 i_dut_reset,  // counter's own reset, observed only
  input  logic [Size-1:0]      i_count,
  input  logic                 i_clear,
  output logic                 o_locked,
  output logic                 o_wrap,
  output logic                 o_mismatch,
  output logic                 o_error,
  output logic                 o_fault,
  output logic [WrapWidth-1:0] o_wraps,
  output logic [ErrWidth-1:0]  o_err_count,
  output logic [Size-1:0]      o_first_expected,
  output logic [Size-1:0]      o_first_actual
);

  localparam int unsigned RunWidth = run_width(LockCycles);

  state_e              r_state;
  state_e              w_state_next;
  logic [Size-1:0]     r_prev;
  logic                r_blank;
  logic                r_wrap;
  logic                r_mismatch;
  logic                r_error;
  logic [Size-1:0]     r_first_expected;
  logic [Size-1:0]     r_first_actual;

  logic [Size-1:0]     w_expected;
  logic                w_step_ok;
  logic                w_prev_ones;
  logic                w_blanked;
  logic [RunWidth-1:0] w_run;
  logic [ErrWidth-1:0] w_err_count;
  logic [ErrWidth-1:0] w_err_next;
  logic                w_lock_now;
  logic                w_fault_now;
  logic                w_run_inc;
  logic                w_wrap_d;
  logic                w_mismatch_d;

  assign w_expected  = r_prev + Size'(1);
  assign w_step_ok   = (i_count == w_expected);
  assign w_prev_ones = &r_prev;
  // No compare on the dut_reset edge nor on the first edge after it falls.
  assign w_blanked   = i_dut_reset | r_blank;
  assign w_err_next  = (&w_err_count) ? w_err_count : w_err_count + ErrWidth'(1);
  assign w_lock_now  = (32'(w_run) == LockCycles - 1);
  assign w_fault_now = (32'(w_err_next) >= MaxErrors);

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= StSync;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; clear overrides everything, FAULT ignores blanking.
  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = StSync;
    end else begin
      unique case (r_state)
        StSync: begin
          if (!w_blanked && w_step_ok && w_lock_now) begin
            w_state_next = StTrack;
          end
        end
        StTrack: begin
          if (w_blanked) begin
            w_state_next = StSync;
          end else if (!w_step_ok) begin
            w_state_next = w_fault_now ? StFault : StSync;
          end
        end
        StFault: w_state_next = StFault;
        default: w_state_next = StSync;
      endcase
    end
  end

  // Per-edge events: run growth in SYNC, wrap/mismatch in TRACK. Clear
  // suppresses every compare-driven event in its cycle.
  always_comb begin
    w_run_inc    = 1'b0;
    w_wrap_d     = 1'b0;
    w_mismatch_d = 1'b0;
    if (!i_clear && !w_blanked) begin
      unique case (r_state)
        StSync: w_run_inc = w_step_ok && !w_lock_now;
        StTrack: begin
          w_wrap_d     = w_step_ok && w_prev_ones;
          w_mismatch_d = !w_step_ok;
        end
        default: ;
      endcase
    end
  end

  // Sample history, pulse outputs, sticky error and first-failure capture.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_prev           <= '0;
      r_blank          <= 1'b0;
      r_wrap           <= 1'b0;
      r_mismatch       <= 1'b0;
      r_error          <= 1'b0;
      r_first_expected <= '0;
      r_first_actual   <= '0;
    end else begin
      r_prev     <= i_count;
      r_blank    <= i_dut_reset;
      r_wrap     <= w_wrap_d;
      r_mismatch <= w_mismatch_d;
      if (i_clear) begin
        r_error          <= 1'b0;
        r_first_expected <= '0;
        r_first_actual   <= '0;
      end else if (w_mismatch_d) begin
        r_error <= 1'b1;
        if (!r_error) begin
          r_first_expected <= w_expected;
          r_first_actual   <= i_count;
        end
      end
    end
  end

  // Any edge that does not extend the run zeroes it (wrong step, blanking,
  // clear, lock, TRACK/FAULT).
  sat_incr #(
    .Width (RunWidth)
  ) u_run (
    .i_clk   (i_clock),
    .i_rst_n (i_reset),
    .i_inc   (w_run_inc),
    .i_zero  (!w_run_inc),
    .o_value (w_run)
  );

  sat_incr #(
    .Width (WrapWidth)
  ) u_wraps (
    .i_clk   (i_clock),
    .i_rst_n (i_reset),
    .i_inc   (w_wrap_d),
    .i_zero  (1'b0),
    .o_value (o_wraps)
  );

  sat_incr #(
    .Width (ErrWidth)
  ) u_errs (
    .i_clk   (i_clock),
    .i_rst_n (i_reset),
    .i_inc   (w_mismatch_d),
    .i_zero  (i_clear),
    .o_value (w_err_count)
  );

  assign o_locked         = (r_state == StTrack);
  assign o_fault          = (r_state == StFault);
  assign o_wrap           = r_wrap;
  assign o_mismatch       = r_mismatch;
  assign o_error          = r_error;
  assign o_err_count      = w_err_count;
  assign o_first_expected = r_first_expected;
  assign o_first_actual   = r_first_actual;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor: stimulus pushes predicted outputs,
// a monitor pops and compares one entry per clock edge.
module tb_counter_monitor;

  localparam int LOCK = 4;
  localparam int MAXE = 3;

  typedef struct packed {
    logic        locked;
    logic        wrap;
    logic        mismatch;
    logic        error;
    logic        fault;
    logic [15:0] wraps;
    logic [7:0]  errs;
    logic [4:0]  fe;
    logic [4:0]  fa;
  } obs_t;

  logic        clk;
  logic        i_reset;
  logic        i_dut_reset;
  logic [4:0]  i_count;
  logic        i_clear;
  logic        o_locked;
  logic        o_wrap;
  logic        o_mismatch;
  logic        o_error;
  logic        o_fault;
  logic [15:0] o_wraps;
  logic [7:0]  o_err_count;
  logic [4:0]  o_first_expected;
  logic [4:0]  o_first_actual;

  int n_checks = 0;
  int n_pass   = 0;
  obs_t sb_q[$];

  // Reference model: mode 0=sync, 1=track, 2=fault.
  int m_mode, m_prev, m_run, m_wraps, m_errs, m_fe, m_fa;
  bit m_blank_prev, m_error, m_wrap, m_mis;
  int src;

  counter_monitor #(
    .Size       (5),
    .LockCycles (LOCK),
    .MaxErrors  (MAXE),
    .WrapWidth  (16),
    .ErrWidth   (8)
  ) dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_dut_reset      (i_dut_reset),
    .i_count          (i_count),
    .i_clear          (i_clear),
    .o_locked         (o_locked),
    .o_wrap           (o_wrap),
    .o_mismatch       (o_mismatch),
    .o_error          (o_error),
    .o_fault          (o_fault),
    .o_wraps          (o_wraps),
    .o_err_count      (o_err_count),
    .o_first_expected (o_first_expected),
    .o_first_actual   (o_first_actual)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_step(input bit rn, input bit dr, input int cnt, input bit clr);
    bit blank;
    bit ok;
    m_wrap = 1'b0;
    m_mis  = 1'b0;
    if (!rn) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_wraps = 0; m_errs = 0;
      m_fe = 0; m_fa = 0; m_blank_prev = 1'b0; m_error = 1'b0;
      return;
    end
    blank = dr || m_blank_prev;
    ok = (cnt == (m_prev + 1) % 32);
    if (clr) begin
      m_errs = 0; m_error = 1'b0; m_fe = 0; m_fa = 0; m_run = 0; m_mode = 0;
    end else if (m_mode != 2) begin
      if (blank) begin
        m_mode = 0; m_run = 0;
      end else if (m_mode == 0) begin
        if (ok) begin
          m_run++;
          if (m_run >= LOCK) begin
            m_mode = 1; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end else if (ok) begin
        if (m_prev == 31) begin
          m_wrap = 1'b1;
          if (m_wraps < 65535) m_wraps++;
        end
      end else begin
        m_mis = 1'b1;
        if (m_errs < 255) m_errs++;
        if (!m_error) begin
          m_fe = (m_prev + 1) % 32;
          m_fa = cnt;
        end
        m_error = 1'b1;
        if (m_errs >= MAXE) m_mode = 2;
        else begin
          m_mode = 0; m_run = 0;
        end
      end
    end
    m_prev = cnt;
    m_blank_prev = dr;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.locked   = (m_mode == 1);
    o.fault    = (m_mode == 2);
    o.wrap     = m_wrap;
    o.mismatch = m_mis;
    o.error    = m_error;
    o.wraps    = 16'(m_wraps);
    o.errs     = 8'(m_errs);
    o.fe       = 5'(m_fe);
    o.fa       = 5'(m_fa);
    return o;
  endfunction

  // Drive one edge's inputs and queue the model's prediction for that edge.
  task automatic cyc(input bit rn, input bit dr, input int cnt, input bit clr);
    @(negedge clk);
    i_reset     = rn;
    i_dut_reset = dr;
    i_count     = 5'(cnt);
    i_clear     = clr;
    model_step(rn, dr, cnt, clr);
    sb_q.push_back(model_obs());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      src = (src + 1) % 32;
      cyc(1'b1, 1'b0, src, 1'b0);
    end
  endtask

  task automatic glitch(input bit clr);
    src = (src + 2) % 32;
    cyc(1'b1, 1'b0, src, clr);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: outputs are presented every edge; compare against the queue head.
  initial begin
    obs_t exp_o;
    obs_t got;
    int edge_n;
    edge_n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_o = sb_q.pop_front();
        got = {o_locked, o_wrap, o_mismatch, o_error, o_fault, o_wraps, o_err_count,
               o_first_expected, o_first_actual};
        n_checks++;
        if (got == exp_o) n_pass++;
        else $display({"FAIL scoreboard edge %0d: got lk=%0b wr=%0b mm=%0b er=%0b ft=%0b ",
                       "wraps=%0d errs=%0d fe=%0d fa=%0d, required lk=%0b wr=%0b mm=%0b ",
                       "er=%0b ft=%0b wraps=%0d errs=%0d fe=%0d fa=%0d"},
                      edge_n, got.locked, got.wrap, got.mismatch, got.error, got.fault,
                      got.wraps, got.errs, got.fe, got.fa, exp_o.locked, exp_o.wrap,
                      exp_o.mismatch, exp_o.error, exp_o.fault, exp_o.wraps, exp_o.errs,
                      exp_o.fe, exp_o.fa);
      end
      edge_n++;
    end
  end

  initial begin
    int r;
    int dr_left;
    bit rn;
    bit dr;
    bit clr;
    i_reset = 1'b0; i_dut_reset = 1'b0; i_count = '0; i_clear = 1'b0;
    src = 0;
    model_step(1'b0, 1'b0, 0, 1'b0);

    // Reset, then a free-running count from 0.
    cyc(1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0);
    settle();
    chk("reset_locked", int'(o_locked), 0);
    chk("reset_err_count", int'(o_err_count), 0);
    cyc(1'b1, 1'b0, 0, 1'b0);
    steps(3);
    settle();
    chk("not_locked_after_3", int'(o_locked), 0);
    steps(1);
    settle();
    chk("locked_after_4", int'(o_locked), 1);
    while (src != 0) steps(1);
    settle();
    chk("wrap_pulse", int'(o_wrap), 1);
    chk("wraps_one", int'(o_wraps), 1);
    chk("no_error_clean_run", int'(o_error), 0);

    // Single illegal step 10->12 and relock.
    while (src != 10) steps(1);
    glitch(1'b0);
    settle();
    chk("mismatch_pulse", int'(o_mismatch), 1);
    chk("err_count_one", int'(o_err_count), 1);
    chk("first_expected", int'(o_first_expected), 11);
    chk("first_actual", int'(o_first_actual), 12);
    chk("unlocked_after_mismatch", int'(o_locked), 0);
    steps(3);
    settle();
    chk("relock_not_yet", int'(o_locked), 0);
    steps(1);
    settle();
    chk("relocked", int'(o_locked), 1);

    // Reach MaxErrors, glitch inside FAULT, then clear.
    steps(2);
    glitch(1'b0);
    steps(4);
    glitch(1'b0);
    settle();
    chk("fault_entered", int'(o_fault), 1);
    chk("err_count_three", int'(o_err_count), 3);
    glitch(1'b0);
    glitch(1'b0);
    settle();
    chk("no_pulse_in_fault", int'(o_mismatch), 0);
    steps(4);
    settle();
    chk("wraps_frozen", int'(o_wraps), 1);
    steps(1);
    cyc(1'b1, 1'b0, (src + 1) % 32, 1'b1);
    src = (src + 1) % 32;
    settle();
    chk("clear_fault", int'(o_fault), 0);
    chk("clear_err_count", int'(o_err_count), 0);
    chk("clear_keeps_wraps", int'(o_wraps), 1);

    // Relock, then the counter is reset for two cycles at 17.
    steps(4);
    while (src != 17) steps(1);
    settle();
    chk("locked_before_dut_reset", int'(o_locked), 1);
    src = 0;
    cyc(1'b1, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b0);
    settle();
    chk("dut_reset_no_mismatch", int'(o_mismatch), 0);
    chk("dut_reset_unlocked", int'(o_locked), 0);
    steps(5);
    settle();
    chk("relock_after_dut_reset", int'(o_locked), 1);

    // Monitor reset mid-TRACK with error set, then clear on an illegal step.
    glitch(1'b0);
    steps(4);
    src = (src + 1) % 32;
    cyc(1'b0, 1'b0, src, 1'b0);
    settle();
    chk("midrun_reset_error", int'(o_error), 0);
    chk("midrun_reset_wraps", int'(o_wraps), 0);
    steps(6);
    glitch(1'b1);
    settle();
    chk("clear_beats_mismatch", int'(o_mismatch), 0);

    // Random traffic against the model.
    dr_left = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      rn = 1'b1; dr = 1'b0; clr = 1'b0;
      if (dr_left > 0) begin
        dr = 1'b1; dr_left--; src = 0;
      end else if (r < 5) begin
        rn = 1'b0; src = (src + 1) % 32;
      end else if (r < 25) begin
        dr = 1'b1; dr_left = int'($urandom_range(0, 2)); src = 0;
      end else if (r < 35) begin
        clr = 1'b1; src = (src + 1) % 32;
      end else if (r < 75) begin
        src = int'($urandom_range(0, 31));
      end else begin
        src = (src + 1) % 32;
      end
      cyc(rn, dr, src, clr);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
